// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for elastic pipeline stage registers: state encodings
// (which double as the occupancy count) and the standard bubble payloads.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Bubble for 32-bit instruction payloads (addi x0, x0, 0).
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  // Bubble for plain control/data bundles.
  localparam logic [31:0] NOP_ZERO = 32'h0000_0000;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// One valid/ready/data channel. The producer side uses the master modport,
// the consumer side uses the slave modport.
interface pipe_stage_skid_if #(
  parameter int WIDTH = 32
) ();

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Count qualifying cycles, parking at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_r <= {W{1'b0}};
    end else if (clr) begin
      count_r <= {W{1'b0}};
    end else if (inc && (count_r != {W{1'b1}})) begin
      count_r <= count_r + W'(1);
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage register: one head entry plus one skid entry so
// downstream back-pressure is absorbed locally. in_ready depends only on the
// registered state and flush; all out_* signals come straight from flops.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] NOP   = {WIDTH{1'b0}},
  parameter int               CNT_W = 16
) (
  input  logic                clk,
  input  logic                rstn,
  pipe_stage_skid_if.slave    up,
  pipe_stage_skid_if.master   dn,
  input  logic                flush,
  input  logic                cnt_clr,
  output logic [1:0]          occupancy,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  state_t           state_r;
  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] skid_r;
  logic             valid_r;

  logic in_ready_s;
  logic accept_s;
  logic emit_s;
  logic stall_s;

  assign in_ready_s = ~flush & (state_r != ST_FULL);
  assign accept_s   = up.valid & in_ready_s;
  assign emit_s     = valid_r & dn.ready;
  assign stall_s    = valid_r & ~dn.ready;

  assign up.ready   = in_ready_s;
  assign dn.valid   = valid_r;
  // main_r is reloaded with NOP whenever the stage drains, so it already
  // reads as the bubble while empty and needs no output mux.
  assign dn.data    = main_r;
  assign occupancy  = state_r;

  // Handshake state machine: flush kills both entries, otherwise move data
  // between input, skid and head according to accept/emit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_EMPTY;
      main_r  <= NOP;
      skid_r  <= NOP;
      valid_r <= 1'b0;
    end else if (flush) begin
      state_r <= ST_EMPTY;
      main_r  <= NOP;
      skid_r  <= NOP;
      valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            main_r  <= up.data;
            state_r <= ST_ONE;
            valid_r <= 1'b1;
          end
        end
        ST_ONE: begin
          if (accept_s && emit_s) begin
            main_r <= up.data;
          end else if (accept_s) begin
            skid_r  <= up.data;
            state_r <= ST_FULL;
          end else if (emit_s) begin
            main_r  <= NOP;
            state_r <= ST_EMPTY;
            valid_r <= 1'b0;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the skid-to-head move can happen.
          if (emit_s) begin
            main_r  <= skid_r;
            skid_r  <= NOP;
            state_r <= ST_ONE;
          end
        end
        default: begin
          state_r <= ST_EMPTY;
          main_r  <= NOP;
          skid_r  <= NOP;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (cnt_clr),
    .inc   (stall_s),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (cnt_clr),
    .inc   (flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: two instances share stimulus, one with 16-bit
// counters and zero bubble, one with 2-bit counters and the instruction NOP.
// Expected behaviour comes from a queue-based model of the stage.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        flush;
  logic        cnt_clr;

  logic [1:0]  occ0;
  logic [15:0] stall0;
  logic [15:0] flush0;
  logic [1:0]  occ1;
  logic [1:0]  stall1;
  logic [1:0]  flush1;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] mq[$];
  int m_stall16, m_flush16, m_stall2, m_flush2;

  pipe_stage_skid_if #(.WIDTH(32)) up0 ();
  pipe_stage_skid_if #(.WIDTH(32)) dn0 ();
  pipe_stage_skid_if #(.WIDTH(32)) up1 ();
  pipe_stage_skid_if #(.WIDTH(32)) dn1 ();

  assign up0.valid = in_valid;
  assign up0.data  = in_data;
  assign dn0.ready = out_ready;
  assign up1.valid = in_valid;
  assign up1.data  = in_data;
  assign dn1.ready = out_ready;

  pipe_stage_skid #(.WIDTH(32), .NOP(32'h0000_0000), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .up(up0), .dn(dn0), .flush(flush), .cnt_clr(cnt_clr),
    .occupancy(occ0), .stall_cnt(stall0), .flush_cnt(flush0)
  );

  pipe_stage_skid #(.WIDTH(32), .NOP(NOP_INSN), .CNT_W(2)) dut_sat (
    .clk(clk), .rstn(rstn), .up(up1), .dn(dn1), .flush(flush), .cnt_clr(cnt_clr),
    .occupancy(occ1), .stall_cnt(stall1), .flush_cnt(flush1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sat_inc(int x, int maxv);
    return (x < maxv) ? x + 1 : x;
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    int  sz  = mq.size();
    bit  acc = in_valid && !flush && (sz < 2);
    bit  emt = (sz > 0) && out_ready;
    bit  stl = (sz > 0) && !out_ready;
    if (cnt_clr) begin
      m_stall16 = 0; m_flush16 = 0; m_stall2 = 0; m_flush2 = 0;
    end else begin
      if (stl) begin
        m_stall16 = sat_inc(m_stall16, 65535);
        m_stall2  = sat_inc(m_stall2, 3);
      end
      if (flush) begin
        m_flush16 = sat_inc(m_flush16, 65535);
        m_flush2  = sat_inc(m_flush2, 3);
      end
    end
    if (flush) begin
      mq.delete();
    end else begin
      if (emt) void'(mq.pop_front());
      if (acc) mq.push_back(in_data);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_stall16 = 0; m_flush16 = 0; m_stall2 = 0; m_flush2 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
    flush = 1'b0; cnt_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checks++; if (dn0.valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %0b exp 0", dn0.valid); end
    checks++; if (dn0.data !== 32'h0) begin errors++; $display("FAIL reset out_data: got %h exp 0", dn0.data); end
    checks++; if (up0.ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %0b exp 1", up0.ready); end
    checks++; if (occ0 !== 2'd0) begin errors++; $display("FAIL reset occupancy: got %0d exp 0", occ0); end
    checks++; if (stall0 !== 16'd0 || flush0 !== 16'd0) begin errors++; $display("FAIL reset counters: got %0d/%0d exp 0/0", stall0, flush0); end
    checks++; if (dn1.data !== NOP_INSN) begin errors++; $display("FAIL reset nop_insn: got %h exp %h", dn1.data, NOP_INSN); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1'b1; in_data = 32'(k);
      tick();
      checks++; if (dn0.data !== 32'(k)) begin errors++; $display("FAIL stream data: got %0d exp %0d", dn0.data, k); end
      checks++; if (occ0 !== 2'd1 || dn0.valid !== 1'b1) begin errors++; $display("FAIL stream occ/valid: got %0d/%0b exp 1/1", occ0, dn0.valid); end
      checks++; if (stall0 !== 16'd0) begin errors++; $display("FAIL stream stall_cnt: got %0d exp 0", stall0); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (occ0 !== 2'd0) begin errors++; $display("FAIL stream drain occ: got %0d exp 0", occ0); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA; tick();
    in_data = 32'hB; tick();
    in_valid = 1'b0;
    #1;
    checks++; if (occ0 !== 2'd2) begin errors++; $display("FAIL bp occupancy: got %0d exp 2", occ0); end
    checks++; if (up0.ready !== 1'b0) begin errors++; $display("FAIL bp in_ready: got %0b exp 0", up0.ready); end
    checks++; if (dn0.data !== 32'hA) begin errors++; $display("FAIL bp head: got %h exp a", dn0.data); end
    tick();
    checks++; if (stall0 !== 16'd2 || 32'(stall0) !== m_stall16) begin errors++; $display("FAIL bp stall_cnt: got %0d exp 2", stall0); end
    out_ready = 1'b1;
    tick();
    checks++; if (dn0.data !== 32'hB || occ0 !== 2'd1) begin errors++; $display("FAIL bp second: got %h occ %0d exp b occ 1", dn0.data, occ0); end
    tick();
    checks++; if (dn0.valid !== 1'b0 || occ0 !== 2'd0) begin errors++; $display("FAIL bp drain: got valid %0b occ %0d exp 0 0", dn0.valid, occ0); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    in_valid = 1'b1; in_data = 32'hA; tick();
    in_data = 32'hB; tick();
    in_data = 32'hC; flush = 1'b1;
    #1;
    checks++; if (up0.ready !== 1'b0) begin errors++; $display("FAIL flush in_ready: got %0b exp 0", up0.ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (occ0 !== 2'd0 || dn0.valid !== 1'b0) begin errors++; $display("FAIL flush occ/valid: got %0d/%0b exp 0/0", occ0, dn0.valid); end
    checks++; if (dn0.data !== 32'h0 || dn1.data !== NOP_INSN) begin errors++; $display("FAIL flush nop: got %h/%h exp 0/%h", dn0.data, dn1.data, NOP_INSN); end
    checks++; if (flush0 !== 16'd1) begin errors++; $display("FAIL flush flush_cnt: got %0d exp 1", flush0); end
    checks++; if (up0.ready !== 1'b1) begin errors++; $display("FAIL flush ready_back: got %0b exp 1", up0.ready); end
    tick();
    checks++; if (occ0 !== 2'd0) begin errors++; $display("FAIL flush no_capture: got occ %0d exp 0", occ0); end
  endtask

  task automatic test_saturation();
    out_ready = 1'b0; cnt_clr = 1'b1; in_valid = 1'b1; in_data = 32'h7;
    tick();
    cnt_clr = 1'b0; in_valid = 1'b0;
    repeat (6) tick();
    checks++; if (stall1 !== 2'd3) begin errors++; $display("FAIL sat stall_cnt2: got %0d exp 3", stall1); end
    checks++; if (stall0 !== 16'd6) begin errors++; $display("FAIL sat stall_cnt16: got %0d exp 6", stall0); end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++; if (stall1 !== 2'd0 || stall0 !== 16'd0) begin errors++; $display("FAIL sat clear: got %0d/%0d exp 0/0", stall1, stall0); end
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] exp_d0, exp_d1;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 15) == 0);
      cnt_clr   = ($urandom_range(0, 31) == 0);
      #1;
      checks++;
      if (up0.ready !== (!flush && mq.size() < 2)) begin
        errors++; $display("FAIL rand in_ready cyc %0d: got %0b exp %0b", i, up0.ready, (!flush && mq.size() < 2));
      end
      tick();
      exp_d0 = (mq.size() > 0) ? mq[0] : 32'h0;
      exp_d1 = (mq.size() > 0) ? mq[0] : NOP_INSN;
      checks++;
      if (dn0.valid !== (mq.size() > 0) || 32'(occ0) !== mq.size() || dn0.data !== exp_d0) begin
        errors++; $display("FAIL rand head cyc %0d: got v%0b o%0d d%h exp v%0b o%0d d%h", i, dn0.valid, occ0, dn0.data, (mq.size() > 0), mq.size(), exp_d0);
      end
      checks++;
      if (dn1.data !== exp_d1 || 32'(occ1) !== mq.size()) begin
        errors++; $display("FAIL rand head2 cyc %0d: got o%0d d%h exp o%0d d%h", i, occ1, dn1.data, mq.size(), exp_d1);
      end
      checks++;
      if (32'(stall0) !== m_stall16 || 32'(flush0) !== m_flush16 || 32'(stall1) !== m_stall2 || 32'(flush1) !== m_flush2) begin
        errors++; $display("FAIL rand counters cyc %0d: got %0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d", i, stall0, flush0, stall1, flush1, m_stall16, m_flush16, m_stall2, m_flush2);
      end
    end
    in_valid = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic test_async_reset();
    flush = 1'b1; tick(); flush = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA; tick();
    in_data = 32'hB; tick();
    in_valid = 1'b0;
    checks++; if (occ0 !== 2'd2) begin errors++; $display("FAIL areset setup occ: got %0d exp 2", occ0); end
    #3;
    rstn = 1'b0;
    model_reset();
    #1;
    checks++; if (occ0 !== 2'd0 || dn0.valid !== 1'b0 || dn0.data !== 32'h0) begin errors++; $display("FAIL areset outputs: got o%0d v%0b d%h exp 0 0 0", occ0, dn0.valid, dn0.data); end
    checks++; if (stall0 !== 16'd0 || flush0 !== 16'd0 || up0.ready !== 1'b1) begin errors++; $display("FAIL areset cnt/ready: got %0d/%0d/%0b exp 0/0/1", stall0, flush0, up0.ready); end
    #2;
    rstn = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h5;
    tick();
    in_valid = 1'b0;
    checks++; if (dn0.data !== 32'h5 || occ0 !== 2'd1) begin errors++; $display("FAIL areset push: got %h occ %0d exp 5 occ 1", dn0.data, occ0); end
    tick();
    checks++; if (occ0 !== 2'd0 || dn0.valid !== 1'b0) begin errors++; $display("FAIL areset alone: got occ %0d v%0b exp 0 0", occ0, dn0.valid); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_saturation();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised elastic pipeline stage register with a valid/ready handshake, a one-entry skid buffer, synchronous flush with bubble (NOP) output, and saturating stall/flush performance counters. It is the generic successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers. It sits between any two core pipeline stages, so back-pressure (for example a memory not ready) is absorbed locally instead of through a global data-ready freeze. Payload is an opaque bundle of `WIDTH` bits that the instantiating stage packs with its control fields and data.

## Interface
- `WIDTH`, 32: payload width in bits; must be ≥1.
- `NOP`, `{WIDTH{1'b0}}`: payload value driven on `out_data` when the stage is empty. This is the bubble encoding.
- `CNT_W`, 16: width of each performance counter; must be ≥1.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream presents `in_data`.
- `in_ready`  out  1  stage can accept this cycle.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  stage presents `out_data`.
- `out_ready`  in  1  downstream accepts this cycle.
- `out_data`  out  WIDTH  head payload, or `NOP` when empty.
- `flush`  in  1  synchronous kill of all held entries (branch taken).
- `cnt_clr`  in  1  synchronous clear of both counters.
- `occupancy`  out  2  number of held entries: 0, 1 or 2.
- `stall_cnt`  out  CNT_W  cycles with `out_valid & ~out_ready`, saturating.
- `flush_cnt`  out  CNT_W  cycles with `flush` asserted, saturating.

## Operation
- Storage: head register `main` (drives `out_data`) and a second register `skid`.
- States: EMPTY (occupancy 0), ONE (occupancy 1), FULL (occupancy 2).
- Handshake signals:
  - `accept = in_valid & in_ready`.
  - `emit = out_valid & out_ready`.
  - `out_valid = (state != EMPTY)`.
  - `in_ready = ~flush & (state != FULL)`.
- State transitions when `flush` = 0:
  - EMPTY, with `accept`: `main` ← `in_data`; go to ONE.
  - ONE, with `accept & emit`: `main` ← `in_data`; stay in ONE.
  - ONE, with `accept & ~emit`: `skid` ← `in_data`; go to FULL.
  - ONE, with `emit & ~accept`: go to EMPTY.
  - FULL, with `emit`: `main` ← `skid`; go to ONE. No accept is possible in FULL.
  - In all other cases, state and registers hold.
- `flush` = 1 has priority over everything:
  - Next state is EMPTY and `main`, `skid` ← `NOP`.
  - `in_ready` = 0, so no accept occurs that cycle.
  - An `emit` in the flush cycle is still a completed transfer for the downstream stage.
- `out_data` equals `main` when `out_valid`, and `NOP` otherwise.
- Data order is strictly FIFO. No entry is duplicated or dropped except by `flush`.
- Counters:
  - `stall_cnt` increments when `out_valid & ~out_ready`.
  - `flush_cnt` increments when `flush` = 1.
  - Both hold at all-ones (saturate).
  - `cnt_clr` forces both to 0 and has priority over increment in the same cycle.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - state EMPTY; `main` = `skid` = `NOP`.
  - `out_valid` = 0, `out_data` = `NOP`, `occupancy` = 0.
  - `stall_cnt` = `flush_cnt` = 0.
  - `in_ready` = 1 while `flush` = 0.
- Reset mid-operation discards all held entries immediately, without waiting for a clock edge.
- Latency: `in_data` accepted at edge N appears on `out_data` after edge N when the stage was EMPTY, or when ONE with a simultaneous emit.
- Throughput: 1 transfer per cycle sustained.
- `in_ready` depends only on state and `flush`. There is no combinational path from `out_ready` to `in_ready`.
- Combinational paths to `out_*`: none from any input. `out_valid`, `out_data` and `occupancy` are pure register outputs.
- Flush at edge N: `out_valid` = 0 and `out_data` = `NOP` from edge N onward. `in_ready` returns to 1 the first cycle `flush` is low.

## Structure
- Shared package `pipe_pkg` holds:
  - the 2-bit state encodings `ST_EMPTY` = 0, `ST_ONE` = 1, `ST_FULL` = 2 (also used directly as `occupancy`);
  - the default `NOP` constant for 32-bit instruction payloads (`32'h0000_0013`) and for zero bundles.
- Sub-module `sat_counter` (parameter `W`; ports `clk`, `rstn`, `clr`, `inc`, `count`) is instantiated twice, once for each counter.
- The handshake/state logic lives in a single always block plus combinational assigns.

## Test plan
- Reset with `WIDTH` = 32, `NOP` = 0: `out_valid` = 0, `out_data` = 0, `in_ready` = 1, `occupancy` = 0, both counters 0.
- Streaming: `out_ready` held 1; `in_data` 1, 2, 3 on consecutive cycles → `out_data` 1, 2, 3 each one cycle later, `occupancy` stays 1, `stall_cnt` = 0.
- Back-pressure:
  - `out_ready` = 0; push 0xA then 0xB → `occupancy` 2, `in_ready` = 0, `out_data` = 0xA.
  - Raise `out_ready` → 0xA then 0xB emitted in order.
  - `stall_cnt` equals the number of low-`out_ready` cycles while `out_valid` was high.
- Flush while FULL (0xA, 0xB held), with `in_valid` = 1 carrying 0xC: next cycle `occupancy` 0, `out_data` = `NOP`, 0xC not captured, `flush_cnt` = 1.
- Saturation with `CNT_W` = 2: hold a stall for 6 cycles → `stall_cnt` = 3; assert `cnt_clr` together with a stall → 0.
- Asynchronous reset asserted between edges while FULL: outputs return to reset values immediately; after release, a fresh push of 0x5 emerges alone.
